// File: rtl/vga_line_fetch_ctrl.sv
// Line-ahead fetch scheduler: fills a ping-pong line buffer from frame memory
// one line ahead of the scan and drives the registered pixel colour.
module vga_line_fetch_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned COLOR_W  = 12,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic               clk_25m,
  input  logic               rst_n,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               valid,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] rgb,
  output logic               underrun,
  input  logic               clr_underrun,
  output logic               busy
);

  localparam int unsigned IDX_W = $clog2(H_ACTIVE);

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_bank, w_bank_nxt;
  logic               r_underrun, w_underrun_nxt;
  logic [COLOR_W-1:0] r_rgb;

  logic [COLOR_W-1:0] r_buf0 [H_ACTIVE];
  logic [COLOR_W-1:0] r_buf1 [H_ACTIVE];

  logic               w_trig;
  logic [9:0]         w_tgt;
  logic               w_tgt_ok;
  logic [ADDR_W-1:0]  w_base;
  logic               w_last;
  logic               w_we;
  logic [COLOR_W-1:0] w_pix_rd;

  assign w_trig   = (pixel_x == '0);
  assign w_tgt    = (pixel_y == 10'(V_TOTAL - 1)) ? '0 : pixel_y + 10'd1;
  assign w_tgt_ok = (w_tgt < 10'(V_ACTIVE));
  assign w_base   = ADDR_W'(w_tgt) * ADDR_W'(H_ACTIVE);
  assign w_last   = (r_idx == IDX_W'(H_ACTIVE - 1));
  assign w_we     = (r_state == FETCH) && mem_ack;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_addr     <= '0;
      r_bank     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_addr     <= w_addr_nxt;
      r_bank     <= w_bank_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // The pending ack is retired first; a same-cycle trigger then overrides the
  // fetch position, so only a non-final ack counts as an underrun.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_addr_nxt     = r_addr;
    w_bank_nxt     = r_bank;
    w_underrun_nxt = r_underrun & ~clr_underrun;

    if (w_we) begin
      if (w_last) begin
        w_state_nxt = IDLE;
      end else begin
        w_idx_nxt  = r_idx + 1'b1;
        w_addr_nxt = r_addr + 1'b1;
      end
    end

    if (w_trig) begin
      if ((r_state == FETCH) && !(w_we && w_last)) begin
        w_underrun_nxt = 1'b1;
      end
      if (w_tgt_ok) begin
        w_state_nxt = FETCH;
        w_idx_nxt   = '0;
        w_addr_nxt  = w_base;
        w_bank_nxt  = w_tgt[0];
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk_25m) begin
    if (w_we) begin
      if (r_bank) begin
        r_buf1[r_idx] <= mem_rdata;
      end else begin
        r_buf0[r_idx] <= mem_rdata;
      end
    end
  end

  assign w_pix_rd = pixel_y[0] ? r_buf1[pixel_x[IDX_W-1:0]] : r_buf0[pixel_x[IDX_W-1:0]];

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= (valid && (pixel_x < 10'(H_ACTIVE))) ? w_pix_rd : '0;
    end
  end

  assign mem_req  = (r_state == FETCH);
  assign busy     = (r_state == FETCH);
  assign mem_addr = r_addr;
  assign rgb      = r_rgb;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Directed bench for vga_line_fetch_ctrl: scan driven line by line against a
// frame memory returning addr[11:0] with selectable per-word ack latency.
`timescale 1ns/1ps
module tb_vga_line_fetch_ctrl;

  logic        clk_25m = 1'b0;
  logic        rst_n;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        valid;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [11:0] mem_rdata;
  logic [11:0] rgb;
  logic        underrun;
  logic        clr_underrun;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  int lat   = 0;
  logic [3:0] r_cnt = '0;

  always #20 clk_25m = ~clk_25m;

  vga_line_fetch_ctrl #(
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .V_TOTAL (525),
    .COLOR_W (12),
    .ADDR_W  (19)
  ) dut (
    .clk_25m     (clk_25m),
    .rst_n       (rst_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .valid       (valid),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .rgb         (rgb),
    .underrun    (underrun),
    .clr_underrun(clr_underrun),
    .busy        (busy)
  );

  // Memory model: ack after `lat` wait cycles of a held request.
  always @(posedge clk_25m) begin
    if (!mem_req || mem_ack) r_cnt <= '0;
    else                     r_cnt <= r_cnt + 4'd1;
  end
  assign mem_ack   = mem_req && (int'(r_cnt) >= lat);
  assign mem_rdata = mem_addr[11:0];

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic        v;
    logic [11:0] exp_rgb;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int x, input int y, input logic v);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    valid   = v;
    @(posedge clk_25m);
    #1;
  endtask

  function automatic logic vis(input int x, input int y);
    return (x < 640) && (y < 480);
  endfunction

  initial begin
    vecs[0]  = '{px: 10'd1,   py: 10'd6,   v: 1'b1, exp_rgb: 12'd3841, exp_busy: 1'b0};
    vecs[1]  = '{px: 10'd639, py: 10'd6,   v: 1'b1, exp_rgb: 12'd383,  exp_busy: 1'b0};
    vecs[2]  = '{px: 10'd640, py: 10'd6,   v: 1'b1, exp_rgb: 12'd0,    exp_busy: 1'b0};
    vecs[3]  = '{px: 10'd799, py: 10'd6,   v: 1'b1, exp_rgb: 12'd0,    exp_busy: 1'b0};
    vecs[4]  = '{px: 10'd100, py: 10'd6,   v: 1'b0, exp_rgb: 12'd0,    exp_busy: 1'b0};
    vecs[5]  = '{px: 10'd100, py: 10'd7,   v: 1'b1, exp_rgb: 12'd484,  exp_busy: 1'b0};
    vecs[6]  = '{px: 10'd639, py: 10'd7,   v: 1'b1, exp_rgb: 12'd1023, exp_busy: 1'b0};
    vecs[7]  = '{px: 10'd5,   py: 10'd8,   v: 1'b1, exp_rgb: 12'd3845, exp_busy: 1'b0};
    vecs[8]  = '{px: 10'd5,   py: 10'd9,   v: 1'b1, exp_rgb: 12'd389,  exp_busy: 1'b0};
    vecs[9]  = '{px: 10'd0,   py: 10'd500, v: 1'b0, exp_rgb: 12'd0,    exp_busy: 1'b0};
    vecs[10] = '{px: 10'd320, py: 10'd6,   v: 1'b1, exp_rgb: 12'd64,   exp_busy: 1'b0};
    vecs[11] = '{px: 10'd0,   py: 10'd479, v: 1'b1, exp_rgb: 12'd384,  exp_busy: 1'b0};

    rst_n = 1'b0; pixel_x = 10'd5; pixel_y = '0; valid = 1'b0; clr_underrun = 1'b0;
    repeat (3) @(posedge clk_25m);
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_busy", 32'(busy), 0);
    #10 rst_n = 1'b1;
    @(posedge clk_25m); #1;

    // Zero-latency fetch of line 6 during line 5
    lat = 0;
    step(0, 5, 1'b1);
    chk("l5_addr_base", 32'(mem_addr), 3840);
    chk("l5_busy_start", 32'(busy), 1);
    chk("l5_req_start", 32'(mem_req), 1);
    for (int x = 1; x < 800; x++) begin
      step(x, 5, vis(x, 5));
      if (x == 300) chk("l5_addr_idx300", 32'(mem_addr), 4140);
      if (x == 639) chk("l5_busy_639", 32'(busy), 1);
      if (x == 640) begin
        chk("l5_busy_640", 32'(busy), 0);
        chk("l5_req_640", 32'(mem_req), 0);
      end
    end

    // Display line 6 from bank 0 while line 7 fills bank 1
    for (int x = 0; x < 800; x++) begin
      step(x, 6, vis(x, 6));
      if (x == 0 || x == 1 || x == 255 || x == 256 || x == 639 || x == 640 || x == 799)
        chk("l6_rgb", 32'(rgb), (x < 640) ? ((3840 + x) & 4095) : 0);
    end
    chk("l6_underrun", 32'(underrun), 0);

    for (int i = 0; i < 12; i++) begin
      step(int'(vecs[i].px), int'(vecs[i].py), vecs[i].v);
      chk($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vecs[i].exp_rgb));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
    end

    // Frame wrap: no fetch in the tail lines, line 0 fetched during line 524
    step(0, 500, 1'b0);
    chk("blank500_req", 32'(mem_req), 0);
    step(0, 523, 1'b0);
    chk("blank523_busy", 32'(busy), 0);
    step(0, 524, 1'b0);
    chk("wrap_addr", 32'(mem_addr), 0);
    chk("wrap_busy", 32'(busy), 1);
    for (int x = 1; x < 800; x++) step(x, 524, 1'b0);
    step(10, 0, 1'b1);
    chk("wrap_rgb", 32'(rgb), 10);

    // Slow memory: line 11 fetch only reaches index 399 before the next trigger
    lat = 1;
    step(0, 10, 1'b1);
    for (int x = 1; x < 800; x++) step(x, 10, vis(x, 10));
    step(0, 11, 1'b1);
    chk("ur_set", 32'(underrun), 1);
    chk("ur_addr_reload", 32'(mem_addr), 7680);
    chk("ur_req_held", 32'(mem_req), 1);
    chk("ur_rgb0", 32'(rgb), 2944);
    for (int x = 1; x < 800; x++) begin
      clr_underrun = (x == 50);
      step(x, 11, vis(x, 11));
      if (x == 50)  chk("clr_alone", 32'(underrun), 0);
      if (x == 399) chk("ur_rgb_new", 32'(rgb), 3343);
      if (x == 400) chk("ur_rgb_stale", 32'(rgb), 784);
    end
    clr_underrun = 1'b1;
    step(0, 12, 1'b1);
    clr_underrun = 1'b0;
    chk("clr_vs_set", 32'(underrun), 1);

    // Reset in the middle of a fetch
    lat = 0;
    step(0, 20, 1'b1);
    for (int x = 1; x <= 300; x++) step(x, 20, vis(x, 20));
    chk("mid_addr_idx300", 32'(mem_addr), 13740);
    chk("mid_underrun", 32'(underrun), 1);
    #5 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rgb", 32'(rgb), 0);
    chk("arst_underrun", 32'(underrun), 0);
    chk("arst_addr", 32'(mem_addr), 0);
    @(posedge clk_25m);
    #10 rst_n = 1'b1;
    step(5, 20, 1'b1);
    step(6, 20, 1'b1);
    step(0, 20, 1'b1);
    chk("post_rst_addr", 32'(mem_addr), 13440);
    chk("post_rst_busy", 32'(busy), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch_ctrl.md
Name: vga_line_fetch_ctrl

Overview:
- Scheduler between the VGA timing generator and the shared frame memory.
- While line L is displayed, fetches the pixels of line L+1 into an internal ping-pong line buffer over a req/ack read port.
- Drives the per-pixel colour for the current scan position with fixed 1-cycle latency.
- Sits between VGASync (pixel_x, pixel_y, valid) and the colour DAC/output pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line (= words fetched per line)
- V_ACTIVE, 480, visible lines per frame
- V_TOTAL, 525, total lines per frame including blanking
- COLOR_W, 12, bits per pixel word
- ADDR_W, 19, frame-memory word address width

Ports:
- clk_25m  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- pixel_x  in  10  scan column from timing generator, 0..799
- pixel_y  in  10  scan line from timing generator, 0..V_TOTAL-1
- valid  in  1  scan position is in the visible area
- mem_req  out  1  read request; held high until acknowledged
- mem_addr  out  ADDR_W  word address, stable while mem_req high
- mem_ack  in  1  read done; mem_rdata valid this cycle; meaningful only while mem_req high; may assert in the same cycle mem_req rises
- mem_rdata  in  COLOR_W  read data
- rgb  out  COLOR_W  pixel colour, registered
- underrun  out  1  sticky: a line fetch did not finish in time
- clr_underrun  in  1  synchronous clear of underrun
- busy  out  1  fetch FSM not IDLE

Behaviour:
- Reset (async, rst_n low): mem_req=0, mem_addr=0, rgb=0, underrun=0, busy=0, FSM=IDLE, fetch index=0. Line-buffer RAM contents are not reset.
- Buffer banks: line n is stored in bank n[0]. Display always reads bank pixel_y[0].
- Trigger: fires in any cycle with pixel_x==0.
  - Target line T = pixel_y+1, or 0 when pixel_y==V_TOTAL-1.
  - If T<V_ACTIVE, start a fetch of T. Otherwise no fetch starts.
- FSM IDLE -> FETCH on trigger with a valid target:
  - Latch T and set index=0.
  - mem_req=1, mem_addr=T*H_ACTIVE (full-width multiply, truncated to ADDR_W).
- FETCH, each cycle with mem_ack=1:
  - Write mem_rdata into bank T[0] at the current index.
  - If index==H_ACTIVE-1: go to IDLE and drop mem_req the next cycle.
  - Otherwise: index+1, mem_addr+1, mem_req stays high.
- One request outstanding at a time. The next request is presented the cycle after an ack.
  - Peak rate is 1 word/cycle; a full line fetch takes at least 640 cycles of the 800-cycle line.
- Trigger while in FETCH (fetch incomplete):
  - Set underrun=1.
  - Abandon the old line; unfetched words keep stale data.
  - Restart immediately for the new target: mem_addr reloads and mem_req stays high.
  - If the new target is invalid, go to IDLE with mem_req=0.
- mem_ack in the same cycle as a trigger: the old word is written first, then the restart applies. underrun is set only if that ack was not the final word.
- clr_underrun and a new underrun in the same cycle: the set wins.
- Output path:
  - rgb <= valid ? bank[pixel_y[0]][pixel_x] : 0, registered, 1-cycle latency.
  - When pixel_x >= H_ACTIVE or valid=0, rgb=0.
- busy = (FSM != IDLE).
- Frame wrap: during line V_TOTAL-1 the controller fetches line 0 into bank 0. No fetch starts during lines V_ACTIVE-1..V_TOTAL-2.

Test Plan:
1. Reset then free-run with a zero-latency memory (mem_ack=mem_req, rdata=addr[11:0]) -> at pixel_x==0, pixel_y==5: mem_addr=3840 for line 6; busy falls after 640 cycles; on line 6 the rgb at pixel_x=k, one cycle later, is (3840+k)[11:0]; underrun stays 0.
2. Ack latency of 2 cycles per word -> fetch still running at the next pixel_x==0 -> underrun=1, the remainder of the line shows stale data, and mem_addr reloads to the next line base in the same cycle.
3. Frame wrap: pixel_y==524, pixel_x==0 -> fetch of line 0 starts with mem_addr=0. pixel_y 479..523 -> mem_req stays 0, busy=0.
4. Blanking: pixel_x in 640..799 or valid=0 -> rgb=0, checked on the cycle after.
5. Assert rst_n low mid-fetch at index 300 -> mem_req, rgb, busy and underrun are 0 immediately. After release, the next trigger restarts at the line base address.
6. clr_underrun pulsed alone -> underrun clears. clr_underrun pulsed in the same cycle as a new underrun event -> underrun stays 1.
